systolic_array_nxn: RTL and testbench

Parametrised output-stationary N x N systolic matrix multiplier. It computes C = A x B, where A is N x K and B is K x N, with K set at run time per job.
- Operands stream in one k-slice per handshake: column k of A and row k of B.
- Internal skew registers diagonalise the operands across the PE grid.
- Results drain one C row per handshake.
- Generalises the fixed 2x2 multiply-accumulate array with: configurable size and widths, a start/done job protocol, valid/ready flow control, a signed mode and accumulator clearing between jobs.

---
 rtl/systolic_array_nxn_if.sv | 33 +++
 rtl/systolic_array_nxn.sv | 164 ++++++++++++++++
 tb/tb_systolic_array_nxn.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_nxn_if.sv
// Streaming port bundle of the N x N systolic multiplier: job control,
// k-slice operand input and C-row result output.
interface systolic_array_nxn_if #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int K_W    = 8
);
  localparam int ROW_W = $clog2(N);

  logic                  start;
  logic [K_W-1:0]        k_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   a_col;
  logic [N*DATA_W-1:0]   b_row;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*ACC_W-1:0]    c_row;
  logic [ROW_W-1:0]      out_row;
  logic                  busy;
  logic                  done;

  modport master (
    output start, k_len, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, c_row, out_row, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, c_row, out_row, busy, done
  );
endinterface

// File: rtl/systolic_array_nxn.sv
// Output-stationary N x N systolic multiplier: C = A x B with run-time K,
// skewed operand injection, flush phase and row-by-row result drain.
module systolic_array_nxn #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int K_W    = 8,
  parameter int SIGNED = 1
) (
  input logic              clk,
  input logic              rst,
  systolic_array_nxn_if.slave bus
);
  localparam int ROW_W = $clog2(N);
  localparam int FL_W  = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [K_W-1:0]   k_len_q, k_cnt_q;
  logic [FL_W-1:0]  fl_cnt_q;
  logic [ROW_W-1:0] row_q;
  logic             done_q;

  logic accept, start_job, last_slice, flush_end, row_hs, last_row;

  assign accept     = (state_q == LOAD) && bus.in_valid;
  assign start_job  = (state_q == IDLE) && bus.start;
  assign last_slice = accept && (k_cnt_q == k_len_q - 1'b1);
  assign flush_end  = (state_q == FLUSH) && (fl_cnt_q == FL_W'(2 * N - 2));
  assign row_hs     = (state_q == DRAIN) && bus.out_ready;
  assign last_row   = (row_q == ROW_W'(N - 1));

  // NOTE: next state gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = (bus.k_len == '0) ? DRAIN : LOAD;
      LOAD:    if (last_slice) state_d = FLUSH;
      FLUSH:   if (flush_end) state_d = DRAIN;
      DRAIN:   if (row_hs && last_row) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_len_q  <= '0;
      k_cnt_q  <= '0;
      fl_cnt_q <= '0;
      row_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= row_hs && last_row;
      fl_cnt_q <= (state_q == FLUSH) ? fl_cnt_q + 1'b1 : '0;
      if (start_job) begin
        k_len_q <= bus.k_len;
        k_cnt_q <= '0;
      end else if (accept) begin
        k_cnt_q <= k_cnt_q + 1'b1;
      end
      if (row_hs) row_q <= last_row ? '0 : row_q + 1'b1;
    end
  end

  // Operand skew lines (stage 0 is the capture register) and PE grid state.
  logic [DATA_W-1:0] a_sk [N][N];
  logic [DATA_W-1:0] b_sk [N][N];
  logic              a_skv [N][N];
  logic              b_skv [N][N];
  logic [DATA_W-1:0] a_q [N][N];
  logic [DATA_W-1:0] b_q [N][N];
  logic              a_qv [N][N];
  logic              b_qv [N][N];
  logic [ACC_W-1:0]  acc [N][N];
  logic [DATA_W-1:0] a_w [N][N];
  logic [DATA_W-1:0] b_w [N][N];
  logic              a_wv [N][N];
  logic              b_wv [N][N];

  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] sa, sb, ps;
    logic        [2*DATA_W-1:0] pu;
    sa = (2*DATA_W)'($signed(a));
    sb = (2*DATA_W)'($signed(b));
    ps = sa * sb;
    pu = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    return (SIGNED != 0) ? ACC_W'(ps) : ACC_W'(pu);
  endfunction

  // PE inputs: left/top edge from the skew line of that lane, else the neighbour's register.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) begin
          a_w[i][j]  = a_sk[i][i];
          a_wv[i][j] = a_skv[i][i];
        end else begin
          a_w[i][j]  = a_q[i][j-1];
          a_wv[i][j] = a_qv[i][j-1];
        end
        if (i == 0) begin
          b_w[i][j]  = b_sk[j][j];
          b_wv[i][j] = b_skv[j][j];
        end else begin
          b_w[i][j]  = b_q[i-1][j];
          b_wv[i][j] = b_qv[i-1][j];
        end
      end
    end
  end

  // NOTE: datapath arrays are reset too, because a reset must discard a partial job mid-flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_sk[i][j] <= '0;  a_skv[i][j] <= 1'b0;
          b_sk[i][j] <= '0;  b_skv[i][j] <= 1'b0;
          a_q[i][j]  <= '0;  a_qv[i][j]  <= 1'b0;
          b_q[i][j]  <= '0;  b_qv[i][j]  <= 1'b0;
          acc[i][j]  <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_sk[i][0]  <= bus.a_col[i*DATA_W +: DATA_W];
        b_sk[i][0]  <= bus.b_row[i*DATA_W +: DATA_W];
        a_skv[i][0] <= accept;
        b_skv[i][0] <= accept;
        for (int d = 1; d < N; d++) begin
          a_sk[i][d]  <= a_sk[i][d-1];
          b_sk[i][d]  <= b_sk[i][d-1];
          a_skv[i][d] <= a_skv[i][d-1];
          b_skv[i][d] <= b_skv[i][d-1];
        end
        for (int j = 0; j < N; j++) begin
          a_q[i][j]  <= a_w[i][j];
          a_qv[i][j] <= a_wv[i][j];
          b_q[i][j]  <= b_w[i][j];
          b_qv[i][j] <= b_wv[i][j];
          if (start_job) acc[i][j] <= '0;
          else if (a_wv[i][j] && b_wv[i][j]) acc[i][j] <= acc[i][j] + mul_ext(a_w[i][j], b_w[i][j]);
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.out_row   = row_q;

  always_comb begin
    bus.c_row = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < N; j++) bus.c_row[j*ACC_W +: ACC_W] = acc[row_q][j];
    end
  end
endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed bench for systolic_array_nxn: a 2x2 and a 4x4 instance share one clock.
module tb_systolic_array_nxn;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   hs4 = 0;
  int   ir4 = 0;

  always #5 clk = ~clk;

  systolic_array_nxn_if #(.N(2), .DATA_W(16), .ACC_W(40), .K_W(8)) if2 ();
  systolic_array_nxn_if #(.N(4), .DATA_W(16), .ACC_W(40), .K_W(8)) if4 ();

  systolic_array_nxn #(.N(2), .DATA_W(16), .ACC_W(40), .K_W(8), .SIGNED(1)) u2 (
    .clk(clk), .rst(rst), .bus(if2.slave));
  systolic_array_nxn #(.N(4), .DATA_W(16), .ACC_W(40), .K_W(8), .SIGNED(1)) u4 (
    .clk(clk), .rst(rst), .bus(if4.slave));

  always @(posedge clk) begin
    if (if4.out_valid && if4.out_ready) hs4 <= hs4 + 1;
    if (if4.in_ready) ir4 <= ir4 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 2x2 job with A=[[1,2],[3,4]], B=[[5,6],[7,8]]; pat gives in_valid per cycle.
  task automatic run_job2(input logic [3:0] pat, input int plen, input bit poke_start, input string tag);
    logic [31:0] ac [2];
    logic [31:0] bc [2];
    int s, n, busy_low;
    ac[0] = {16'd3, 16'd1};  ac[1] = {16'd4, 16'd2};
    bc[0] = {16'd6, 16'd5};  bc[1] = {16'd8, 16'd7};
    if2.k_len = 8'd2;
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    n_checks++;
    if (if2.busy !== 1'b1 || if2.in_ready !== 1'b1) $display("FAIL %s_start: busy=%b in_ready=%b want 1 1", tag, if2.busy, if2.in_ready);
    else n_pass++;
    busy_low = 0;
    s = 0;
    for (int p = 0; p < plen; p++) begin
      if2.in_valid = pat[p];
      if2.a_col = pat[p] ? ac[s] : 32'hdead_beef;
      if2.b_row = pat[p] ? bc[s] : 32'hcafe_f00d;
      tick();
      if (if2.busy !== 1'b1) busy_low++;
      if (pat[p]) s++;
    end
    if2.in_valid = 1'b0;
    n_checks++;
    if (if2.in_ready !== 1'b0) $display("FAIL %s_in_ready_drop: got %b want 0", tag, if2.in_ready);
    else n_pass++;
    n = 0;
    while (if2.out_valid !== 1'b1 && n < 40) begin
      tick();
      if (if2.busy !== 1'b1) busy_low++;
      n++;
    end
    n_checks++;
    if (n != 3) $display("FAIL %s_flush_len: got %0d cycles want 3", tag, n);
    else n_pass++;
    if (poke_start) begin
      if2.out_ready = 1'b0;
      if2.start = 1'b1;
      tick();
      if2.start = 1'b0;
      n_checks++;
      if ({if2.out_valid, if2.out_row, if2.c_row} !== {1'b1, 1'b0, 40'd22, 40'd19})
        $display("FAIL %s_start_in_drain: got v=%b row=%0d c=%h want 1 0 %h", tag, if2.out_valid, if2.out_row, if2.c_row, {40'd22, 40'd19});
      else n_pass++;
    end
    if2.out_ready = 1'b1;
    n_checks++;
    if ({if2.out_row, if2.c_row} !== {1'b0, 40'd22, 40'd19})
      $display("FAIL %s_row0: got row=%0d c=%h want 0 %h", tag, if2.out_row, if2.c_row, {40'd22, 40'd19});
    else n_pass++;
    tick();
    n_checks++;
    if ({if2.out_row, if2.c_row, if2.done, if2.busy} !== {1'b1, 40'd50, 40'd43, 1'b0, 1'b1})
      $display("FAIL %s_row1: got row=%0d c=%h done=%b busy=%b want 1 %h 0 1", tag, if2.out_row, if2.c_row, if2.done, if2.busy, {40'd50, 40'd43});
    else n_pass++;
    tick();
    if2.out_ready = 1'b0;
    n_checks++;
    if ({if2.done, if2.busy, if2.out_valid, if2.out_row} !== 4'b1000)
      $display("FAIL %s_done: got done=%b busy=%b ov=%b row=%0d want 1 0 0 0", tag, if2.done, if2.busy, if2.out_valid, if2.out_row);
    else n_pass++;
    n_checks++;
    if (busy_low != 0) $display("FAIL %s_busy_hold: got %0d low cycles want 0", tag, busy_low);
    else n_pass++;
    tick();
    n_checks++;
    if (if2.done !== 1'b0) $display("FAIL %s_done_pulse: got %b want 0", tag, if2.done);
    else n_pass++;
  endtask

  // 4x4 job; stall>0 holds out_ready low that many cycles on row 2.
  task automatic job4(input int kl, input logic [63:0] as [4], input logic [63:0] bs [4],
                      input logic [159:0] exp [4], input int stall, input string tag);
    int n, hs0, ir0;
    hs0 = hs4;
    ir0 = ir4;
    if4.k_len = 8'(kl);
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    n_checks++;
    if (if4.busy !== 1'b1) $display("FAIL %s_busy: got %b want 1", tag, if4.busy);
    else n_pass++;
    for (int s = 0; s < kl; s++) begin
      if4.in_valid = 1'b1;
      if4.a_col = as[s];
      if4.b_row = bs[s];
      tick();
    end
    if4.in_valid = 1'b0;
    if (kl > 0) begin
      n = 0;
      while (if4.out_valid !== 1'b1 && n < 50) begin
        tick();
        n++;
      end
      n_checks++;
      if (n != 7) $display("FAIL %s_flush_len: got %0d cycles want 7", tag, n);
      else n_pass++;
    end
    for (int r = 0; r < 4; r++) begin
      if4.out_ready = 1'b1;
      n_checks++;
      if ({if4.out_valid, if4.out_row, if4.c_row} !== {1'b1, 2'(r), exp[r]})
        $display("FAIL %s_row%0d: got v=%b row=%0d c=%h want 1 %0d %h", tag, r, if4.out_valid, if4.out_row, if4.c_row, r, exp[r]);
      else n_pass++;
      if (r == 2 && stall > 0) begin
        if4.out_ready = 1'b0;
        for (int c = 0; c < stall; c++) begin
          tick();
          n_checks++;
          if ({if4.out_valid, if4.out_row, if4.c_row} !== {1'b1, 2'd2, exp[2]})
            $display("FAIL %s_stall%0d: got v=%b row=%0d c=%h want 1 2 %h", tag, c, if4.out_valid, if4.out_row, if4.c_row, exp[2]);
          else n_pass++;
        end
        if4.out_ready = 1'b1;
      end
      tick();
    end
    if4.out_ready = 1'b0;
    n_checks++;
    if ({if4.done, if4.busy, if4.out_valid, if4.out_row} !== 5'b10000)
      $display("FAIL %s_done: got done=%b busy=%b ov=%b row=%0d want 1 0 0 0", tag, if4.done, if4.busy, if4.out_valid, if4.out_row);
    else n_pass++;
    n_checks++;
    if (hs4 - hs0 != 4) $display("FAIL %s_handshakes: got %0d want 4", tag, hs4 - hs0);
    else n_pass++;
    if (kl == 0) begin
      n_checks++;
      if (ir4 - ir0 != 0) $display("FAIL %s_in_ready_seen: got %0d cycles want 0", tag, ir4 - ir0);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (if4.done !== 1'b0) $display("FAIL %s_done_pulse: got %b want 0", tag, if4.done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n_checks++;
    if ({if2.in_ready, if2.out_valid, if2.busy, if2.done, if2.out_row} !== 5'b0 || if2.c_row !== '0)
      $display("FAIL reset_n2: got ir=%b ov=%b busy=%b done=%b row=%0d c=%h want all 0", if2.in_ready, if2.out_valid, if2.busy, if2.done, if2.out_row, if2.c_row);
    else n_pass++;
    n_checks++;
    if ({if4.in_ready, if4.out_valid, if4.busy, if4.done, if4.out_row} !== 6'b0 || if4.c_row !== '0)
      $display("FAIL reset_n4: got ir=%b ov=%b busy=%b done=%b row=%0d c=%h want all 0", if4.in_ready, if4.out_valid, if4.busy, if4.done, if4.out_row, if4.c_row);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_job2(4'b0011, 2, 1'b0, "basic");
  endtask

  task automatic test_bubbles();
    run_job2(4'b1001, 4, 1'b0, "bubbles");
  endtask

  task automatic test_signed();
    logic [63:0]  as [4];
    logic [63:0]  bs [4];
    logic [159:0] exp [4];
    for (int s = 0; s < 4; s++) begin
      as[s]  = 64'hFFFF << (16 * s);
      bs[s]  = {4{16'd3}};
      exp[s] = {4{40'hFF_FFFF_FFFD}};
    end
    job4(4, as, bs, exp, 0, "signed");
  endtask

  task automatic test_backpressure();
    logic [63:0]  as [4];
    logic [63:0]  bs [4];
    logic [159:0] exp [4];
    for (int s = 0; s < 4; s++) begin
      as[s] = 64'(s + 1) << (16 * s);
      bs[s] = {16'(10 * s + 3), 16'(10 * s + 2), 16'(10 * s + 1), 16'(10 * s)};
    end
    exp[0] = {40'd3,   40'd2,   40'd1,   40'd0};
    exp[1] = {40'd26,  40'd24,  40'd22,  40'd20};
    exp[2] = {40'd69,  40'd66,  40'd63,  40'd60};
    exp[3] = {40'd132, 40'd128, 40'd124, 40'd120};
    job4(4, as, bs, exp, 5, "backpressure");
  endtask

  task automatic test_zero_k();
    logic [63:0]  as [4];
    logic [63:0]  bs [4];
    logic [159:0] exp [4];
    for (int s = 0; s < 4; s++) begin
      as[s]  = '0;
      bs[s]  = '0;
      exp[s] = '0;
    end
    job4(0, as, bs, exp, 0, "zero_k");
  endtask

  task automatic test_reset_mid_load();
    if2.k_len = 8'd2;
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    if2.in_valid = 1'b1;
    if2.a_col = {16'd3, 16'd1};
    if2.b_row = {16'd6, 16'd5};
    tick();
    if2.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({if2.in_ready, if2.out_valid, if2.busy, if2.done, if2.out_row} !== 5'b0 || if2.c_row !== '0)
      $display("FAIL mid_load_reset: got ir=%b ov=%b busy=%b done=%b row=%0d c=%h want all 0", if2.in_ready, if2.out_valid, if2.busy, if2.done, if2.out_row, if2.c_row);
    else n_pass++;
    run_job2(4'b0011, 2, 1'b0, "after_reset");
  endtask

  task automatic test_start_in_drain();
    run_job2(4'b0011, 2, 1'b1, "start_in_drain");
  endtask

  initial begin
    rst = 1'b1;
    if2.start = 1'b0;  if2.k_len = '0;  if2.in_valid = 1'b0;
    if2.a_col = '0;    if2.b_row = '0;  if2.out_ready = 1'b0;
    if4.start = 1'b0;  if4.k_len = '0;  if4.in_valid = 1'b0;
    if4.a_col = '0;    if4.b_row = '0;  if4.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_signed();
    test_backpressure();
    test_zero_k();
    test_reset_mid_load();
    test_start_in_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
